// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline stages.
// Holds the canonical NOP, default PCs and the fetch-stage enums.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_SEQ,
    PC_REDIRECT,
    PC_TRAP
  } pc_sel_e;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {valid, pc, pc_plus4, inst} between stages.
// Priority is reset > flush > load > hold; a flush keeps the PC fields.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int WIDTH      = XLEN,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_flush,
  input  logic [WIDTH-1:0]      i_pc,
  input  logic [WIDTH-1:0]      i_pc_plus4,
  input  logic [INST_WIDTH-1:0] i_inst,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_pc,
  output logic [WIDTH-1:0]      o_pc_plus4,
  output logic [INST_WIDTH-1:0] o_inst
);

  logic                  r_valid;
  logic [WIDTH-1:0]      r_pc;
  logic [WIDTH-1:0]      r_pc_plus4;
  logic [INST_WIDTH-1:0] r_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_inst     <= INST_WIDTH'(NOP_INST);
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_inst  <= INST_WIDTH'(NOP_INST);
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_inst     <= i_inst;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_inst     = r_inst;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the async instruction ROM and fills IF/ID.
// Handles stalls, redirects, misaligned targets and fetches past the ROM end.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH      = XLEN,
  parameter int               INST_WIDTH = 32,
  parameter int               INST_NUM   = 1024,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] TRAP_PC    = WIDTH'(DEFAULT_TRAP_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [WIDTH-1:0]      redirect_target,
  input  logic [INST_WIDTH-1:0] instruction,
  output logic [WIDTH-1:0]      pc_address,
  output logic                  if_valid,
  output logic [WIDTH-1:0]      if_pc,
  output logic [WIDTH-1:0]      if_pc_plus4,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic                  fetch_fault,
  output logic                  misalign_err,
  output logic [31:0]           fetch_count
);

  localparam longint unsigned ROM_BYTES = 64'(INST_NUM) * 64'd4;

  logic [WIDTH-1:0] r_pc;
  fetch_state_e     r_state;
  logic             r_fetch_fault;
  logic             r_misalign_err;
  logic [31:0]      r_fetch_count;

  fetch_state_e     w_state_next;
  pc_sel_e          w_pc_sel;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_plus4;
  logic             w_in_range;
  logic             w_aligned;
  logic             w_load;
  logic             w_flush;
  logic             w_set_fault;
  logic             w_set_misalign;
  logic             w_count_inc;

  assign w_pc_plus4 = r_pc + WIDTH'(4);
  assign w_in_range = 64'(r_pc) < ROM_BYTES;
  assign w_aligned  = (redirect_target[1:0] == 2'b00);

  // HALT remembers that fetch ran off the ROM; only a redirect leaves it,
  // while the visible fetch_fault flag stays sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH_RUN;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_sel       = PC_HOLD;
    w_load         = 1'b0;
    w_flush        = 1'b0;
    w_set_fault    = 1'b0;
    w_set_misalign = 1'b0;
    w_count_inc    = 1'b0;
    if (redirect_valid) begin
      w_flush      = 1'b1;
      w_state_next = FETCH_RUN;
      if (w_aligned) begin
        w_pc_sel = PC_REDIRECT;
      end else begin
        w_pc_sel       = PC_TRAP;
        w_set_misalign = 1'b1;
      end
    end else if (r_state == FETCH_HALT) begin
      w_flush = 1'b1;
    end else if (stall) begin
      w_pc_sel = PC_HOLD;
    end else if (w_in_range) begin
      w_load      = 1'b1;
      w_pc_sel    = PC_SEQ;
      w_count_inc = 1'b1;
    end else begin
      w_flush      = 1'b1;
      w_set_fault  = 1'b1;
      w_state_next = FETCH_HALT;
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_pc_sel)
      PC_SEQ:      w_pc_next = w_pc_plus4;
      PC_REDIRECT: w_pc_next = redirect_target;
      PC_TRAP:     w_pc_next = TRAP_PC;
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_fetch_fault  <= 1'b0;
      r_misalign_err <= 1'b0;
      r_fetch_count  <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_set_fault)    r_fetch_fault  <= 1'b1;
      if (w_set_misalign) r_misalign_err <= 1'b1;
      if (w_count_inc && (r_fetch_count != '1))
        r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  if_id_reg #(
    .WIDTH      (WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_inst     (instruction),
    .o_valid    (if_valid),
    .o_pc       (if_pc),
    .o_pc_plus4 (if_pc_plus4),
    .o_inst     (if_inst)
  );

  assign pc_address   = r_pc;
  assign fetch_fault  = r_fetch_fault;
  assign misalign_err = r_misalign_err;
  assign fetch_count  = r_fetch_count;

endmodule
